// File: rtl/fir_pkg.sv
// Shared defaults and width helpers for the decimating accumulator.
package fir_pkg;

    localparam int DATA_W_DEF = 9;
    localparam int DECIM_DEF  = 4;

    // Accumulator must hold DECIM full-scale samples without wrapping.
    function automatic int acc_width(input int data_w, input int decim);
        return data_w + $clog2(decim);
    endfunction

    localparam int ACC_W_DEF = acc_width(DATA_W_DEF, DECIM_DEF);

endpackage

// File: rtl/fir_decimator_if.sv
// Sample input stream and decimated output stream of fir_decimator.
//
// Handshake: in_valid qualifies in_data in the same cycle and is never
// back-pressured. out_valid means the output FIFO is non-empty; a transfer
// happens on every rising clk edge where out_valid && out_ready. out_data
// holds the oldest entry and only changes after a transfer or when the
// FIFO goes from empty to non-empty.
interface fir_decimator_if
    import fir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;

    // Driver / consumer side (testbench or upstream logic).
    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data
    );

    // Decimator side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/fir_sync_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when a
// pop happens in the same cycle. Reads 0 while empty.
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEF,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Accept/reject decisions and next pointer/level values; clear wins.
    always_comb begin
        pop_ok   = !clear && pop && !empty;
        push_ok  = !clear && push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage; contents are don't-care outside the occupied window.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end
endmodule

// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator: sums DECIM accepted samples, rounds the sum
// by 2^log2(DECIM) (half toward +inf) and queues the result in a FIFO.
module fir_decimator
    import fir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DECIM  = DECIM_DEF,
    parameter int DEPTH  = 4,
    localparam int SHIFT = $clog2(DECIM),
    localparam int ACC_W = acc_width(DATA_W, DECIM),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    fir_decimator_if.slave   bus,
    output logic             overflow,
    output logic [LVL_W-1:0] level
);
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic        [SHIFT-1:0]  phase_q, phase_d;
    logic                     overflow_q, overflow_d;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  sum;
    logic        [DATA_W-1:0] dump_data;
    logic                     dump;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic        [DATA_W-1:0] fifo_rd_data;

    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_rd_data;
    assign overflow      = overflow_q;

    // Adding 2^(S-1) before an arithmetic shift by S is the same as taking
    // the upper bits and adding bit S-1; the result always fits DATA_W.
    always_comb begin
        sample_ext = {{SHIFT{bus.in_data[DATA_W-1]}}, bus.in_data};
        sum        = acc_q + sample_ext;
        dump_data  = sum[ACC_W-1:SHIFT] + DATA_W'(sum[SHIFT-1]);
    end

    // Phase/accumulator sequencing; clear discards the sample in flight.
    always_comb begin
        acc_d      = acc_q;
        phase_d    = phase_q;
        overflow_d = overflow_q;
        dump       = 1'b0;
        if (clear) begin
            acc_d      = '0;
            phase_d    = '0;
            overflow_d = 1'b0;
        end else if (bus.in_valid) begin
            if (phase_q == SHIFT'(DECIM - 1)) begin
                dump    = 1'b1;
                acc_d   = '0;
                phase_d = '0;
                if (fifo_full && !pop) begin
                    overflow_d = 1'b1;
                end
            end else begin
                acc_d   = sum;
                phase_d = phase_q + SHIFT'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            phase_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
        end
    end

    fir_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .push    (dump),
        .wr_data (dump_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );
endmodule

// File: doc/fir_decimator.md
FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 SHALL have parameter DATA_W, default 9, meaning sample width (signed).
REQ-002 SHALL have parameter DECIM, default 4, meaning decimation ratio; power of two, at least 2.
REQ-003 SHALL have parameter DEPTH, default 4, meaning output FIFO entries; at least 2.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port clear, input, 1, synchronous flush of accumulator, phase and FIFO.
REQ-007 SHALL have port in_valid, input, 1, sample strobe; same-cycle qualifier for in_data.
REQ-008 SHALL have port in_data, input, signed DATA_W, filter output sample.
REQ-009 SHALL have port out_valid, output, 1, FIFO non-empty.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts out_data.
REQ-011 SHALL have port out_data, output, signed DATA_W, head-of-FIFO decimated sample.
REQ-012 SHALL have port overflow, output, 1, sticky: decimated sample dropped.
REQ-013 SHALL have port level, output, $clog2(DEPTH+1), current FIFO occupancy.

Function
REQ-014 SHALL keep phase counter 0..DECIM-1; it advances only on an accepted in_valid cycle and wraps DECIM-1 -> 0.
REQ-015 SHALL hold signed accumulator of width DATA_W+log2(DECIM); in_data is sign-extended before adding.
REQ-016 SHALL, on in_valid with phase < DECIM-1, load acc <= acc + in_data.
REQ-017 SHALL, on in_valid with phase == DECIM-1 (dump), form sum = acc + in_data and reset acc to 0 at the same edge.
REQ-018 SHALL compute the dump result as (sum + 2^(S-1)) >>> S, S = log2(DECIM): arithmetic shift, round half toward +inf, truncated to DATA_W (always in range; no saturation).
REQ-019 SHALL push the dump result into the FIFO at the dump edge; out_valid SHALL rise the following cycle (latency 1 from last input sample).
REQ-020 SHALL treat a push as accepted when level < DEPTH, or when level == DEPTH and a pop occurs in the same cycle.
REQ-021 SHALL, on a rejected push, discard the result, leave FIFO contents unchanged, and set overflow; overflow clears only on rst or clear.
REQ-022 SHALL pop on out_valid && out_ready; out_data SHALL present the oldest entry and change only after a pop or onto an empty FIFO.
REQ-023 SHALL, on a simultaneous push and pop, keep level unchanged and preserve order.
REQ-024 SHALL, with out_ready high while empty, do nothing; no underflow.
REQ-025 SHALL give clear priority over in_valid and pop: it zeroes acc, phase and level and clears overflow; the sample present that cycle is discarded.
REQ-026 SHALL, while in_valid is low, hold acc and phase indefinitely.

Reset
REQ-027 SHALL, while rst is high at a clk edge, set acc=0, phase=0, level=0, out_valid=0, overflow=0, and out_data=0; rst has priority over clear and all data-path activity.
REQ-028 SHALL, when rst asserts mid-accumulation, discard the partial sum; the first accepted sample after rst is phase 0.

Structure
REQ-029 SHALL put DATA_W default, DECIM default and the derived accumulator width function/constant in shared package fir_pkg.
REQ-030 SHALL instantiate one sub-module fir_sync_fifo (parameterised width/depth, push/pop/level/full/empty, synchronous active-high reset and clear); the decimator holds only phase, accumulator and rounding.

Verification
REQ-031 SHALL check: DECIM=4, in_data 1,2,3,4 on consecutive in_valid -> one entry out_data=3, out_valid one cycle after 4th sample.
REQ-032 SHALL check: in_data -1,-2,-3,-4 -> out_data=-2; 255 x4 -> 255; -256 x4 -> -256.
REQ-033 SHALL check: out_ready=0, 5 dumps with DEPTH=4 -> level=4, overflow=1, popped sequence equals first 4 results in order.
REQ-034 SHALL check: level=4 with out_ready=1 on the dump cycle -> push accepted, level stays 4, overflow stays 0.
REQ-035 SHALL check: in_valid gaps (1,_,2,_,_,3,4) -> identical result 3 as the back-to-back case.
REQ-036 SHALL check: rst or clear pulsed after 2 samples, then 1,2,3,4 -> out_data=3, level=0 and overflow=0 immediately after the pulse.
